panel_scan_ctrl: RTL

PANEL_SCAN_CTRL -- requirements
Module: panel_scan_ctrl

---
 rtl/panel_scan_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/panel_scan_ctrl.sv
// panel_scan_ctrl: HUB75-style LED panel scan controller.
// Scans N_ROWS_MAX/2 row pairs with binary-coded modulation. For each row and bit plane it
// shifts N_COLS_MAX pixels out of the framebuffer, latches them, then enables the outputs for
// BASE_CYCLES << bit cycles.
//
// Optional macro PANEL_SCAN_BLANK_EN adds a BLANK dead-time state after every DISPLAY. In that
// build the row address changes on BLANK entry instead of in LATCH.
//
// Ports
//   clk, rst          : sole clock, synchronous active-high reset
//   ctrl_en           : scan enable; a deassert takes effect only at frame end
//   ctrl_bitdepth     : bits per colour; 0 or >BITDEPTH_MAX selects BITDEPTH_MAX
//   swap_req/swap_ack : buffer-swap request pulse / swap-done pulse at frame end
//   frame_done        : pulse on the last DISPLAY cycle of a frame
//   fb_r_*            : framebuffer read port, one-cycle read latency on fb_r_dout
//   hub_*             : panel shift clock, latch, active-low output enable, row address, data
module panel_scan_ctrl #(
   parameter int unsigned N_ROWS_MAX   = 64,
   parameter int unsigned N_COLS_MAX   = 256,
   parameter int unsigned BITDEPTH_MAX = 8,
   parameter int unsigned CTRL_WIDTH   = 32,
   parameter int unsigned BASE_CYCLES  = 4,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       ctrl_en,
   input  logic [CTRL_WIDTH-1:0]                      ctrl_bitdepth,
   input  logic                                       swap_req,
   output logic                                       swap_ack,
   output logic                                       frame_done,
   output logic                                       fb_r_en,
   output logic                                       fb_r_buffer,
   output logic [$clog2(N_ROWS_MAX*N_COLS_MAX)-2:0]   fb_r_addr,
   output logic [$clog2(BITDEPTH_MAX)-1:0]            fb_r_bit,
   input  logic [5:0]                                 fb_r_dout,
   output logic                                       hub_clk,
   output logic                                       hub_lat,
   output logic                                       hub_oe_n,
   output logic [$clog2(N_ROWS_MAX/2)-1:0]            hub_row,
   output logic [5:0]                                 hub_rgb
);

   localparam int unsigned AW       = $clog2(N_ROWS_MAX*N_COLS_MAX) - 1;
   localparam int unsigned BW       = $clog2(BITDEPTH_MAX);
   localparam int unsigned RW       = $clog2(N_ROWS_MAX/2);
   localparam int unsigned DW       = $clog2(BITDEPTH_MAX+1);
   localparam int unsigned ShiftLen = 2 * N_COLS_MAX;
   localparam int unsigned DispMax  = BASE_CYCLES << (BITDEPTH_MAX - 1);
   localparam int unsigned CntMax0  = (ShiftLen > DispMax) ? ShiftLen : DispMax;
   localparam int unsigned CntMax   = (CntMax0 > BLANK_CYCLES) ? CntMax0 : BLANK_CYCLES;
   localparam int unsigned CW       = $clog2(CntMax);

`ifdef PANEL_SCAN_BLANK_EN
   typedef enum logic [2:0] {StIdle, StShift, StLatch, StDisplay, StBlank} state_e;
`else
   typedef enum logic [1:0] {StIdle, StShift, StLatch, StDisplay} state_e;
`endif

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   row_q, row_d, row_nxt;
   logic [BW-1:0]   bit_q, bit_d;
   logic [DW-1:0]   depth_q, depth_d, depth_smp;
   logic            pend_q, pend_d;
   logic            buf_q, buf_d;
   logic [5:0]      rgb_q, rgb_d;
   logic [RW-1:0]   hrow_q, hrow_d;
`ifdef PANEL_SCAN_BLANK_EN
   logic            stop_q, stop_d;
`endif

   logic last_row, last_bit, disp_last, frame_end;

   // Effective depth from the control input; out-of-range values fall back to the maximum.
   always_comb begin
      if (ctrl_bitdepth == '0 || ctrl_bitdepth > CTRL_WIDTH'(BITDEPTH_MAX)) begin
         depth_smp = DW'(BITDEPTH_MAX);
      end else begin
         depth_smp = ctrl_bitdepth[DW-1:0];
      end
   end

   assign last_row  = (32'(row_q) == N_ROWS_MAX/2 - 1);
   assign last_bit  = (32'(bit_q) + 1 >= 32'(depth_q));
   assign disp_last = (32'(cnt_q) == (BASE_CYCLES << bit_q) - 1);
   assign frame_end = (state_q == StDisplay) && disp_last && last_bit && last_row;
   assign row_nxt   = last_row ? '0 : row_q + RW'(1);

   assign fb_r_buffer = buf_q;
   assign fb_r_bit    = bit_q;
   assign hub_rgb     = rgb_q;
   assign hub_row     = hrow_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      bit_d   = bit_q;
      depth_d = depth_q;
      pend_d  = pend_q | swap_req;
      buf_d   = buf_q;
      rgb_d   = rgb_q;
      hrow_d  = hrow_q;
`ifdef PANEL_SCAN_BLANK_EN
      stop_d  = stop_q;
`endif
      fb_r_en    = 1'b0;
      fb_r_addr  = '0;
      hub_clk    = 1'b0;
      hub_lat    = 1'b0;
      hub_oe_n   = 1'b1;
      frame_done = 1'b0;
      swap_ack   = 1'b0;

      case (state_q)
         StIdle: begin
            if (ctrl_en) begin
               state_d = StShift;
               cnt_d   = '0;
               row_d   = '0;
               bit_d   = '0;
               depth_d = depth_smp;
            end
         end

         // Even k issues a read, odd k captures the returned pixel pair.
         StShift: begin
            fb_r_en   = ~cnt_q[0];
            fb_r_addr = AW'(32'(row_q) * N_COLS_MAX + 32'(cnt_q >> 1));
            hub_clk   = ~cnt_q[0] && (cnt_q >= CW'(2));
            if (cnt_q[0]) begin
               rgb_d = fb_r_dout;
            end
            if (32'(cnt_q) == ShiftLen - 1) begin
               state_d = StLatch;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         // Cycle 0 carries the final shift clock edge; cycle 1 pulses the latch.
         StLatch: begin
            if (cnt_q == '0) begin
               hub_clk = 1'b1;
               cnt_d   = CW'(1);
`ifndef PANEL_SCAN_BLANK_EN
               hrow_d  = row_q;
`endif
            end else begin
               hub_lat = 1'b1;
               state_d = StDisplay;
               cnt_d   = '0;
            end
         end

         StDisplay: begin
            hub_oe_n = 1'b0;
            if (disp_last) begin
               cnt_d = '0;
               if (last_bit) begin
                  bit_d = '0;
                  row_d = row_nxt;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
               if (frame_end) begin
                  frame_done = 1'b1;
                  swap_ack   = pend_q | swap_req;
                  pend_d     = 1'b0;
                  depth_d    = depth_smp;
                  if (pend_q | swap_req) begin
                     buf_d = ~buf_q;
                  end
               end
`ifdef PANEL_SCAN_BLANK_EN
               // Row moves while outputs are dark to avoid ghosting.
               state_d = StBlank;
               hrow_d  = last_bit ? row_nxt : row_q;
               stop_d  = frame_end && !ctrl_en;
`else
               state_d = (frame_end && !ctrl_en) ? StIdle : StShift;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

`ifdef PANEL_SCAN_BLANK_EN
         StBlank: begin
            if (32'(cnt_q) == BLANK_CYCLES - 1) begin
               cnt_d   = '0;
               state_d = stop_q ? StIdle : StShift;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         row_q   <= '0;
         bit_q   <= '0;
         depth_q <= '0;
         pend_q  <= 1'b0;
         buf_q   <= 1'b0;
         rgb_q   <= '0;
         hrow_q  <= '0;
`ifdef PANEL_SCAN_BLANK_EN
         stop_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         bit_q   <= bit_d;
         depth_q <= depth_d;
         pend_q  <= pend_d;
         buf_q   <= buf_d;
         rgb_q   <= rgb_d;
         hrow_q  <= hrow_d;
`ifdef PANEL_SCAN_BLANK_EN
         stop_q  <= stop_d;
`endif
      end
   end

endmodule
